kl8_printer_iot: RTL and testbench
==================================

// Module: kl8_printer_iot
// PURPOSE
// - Teleprinter output IOT device (KL8-style, device 04): one of the peripherals
//   on the negative I/O bus driven by the bus-driver stage.
// - Decodes BMB device select and IOP1/2/4 pulses, latches AC4-11 from BAC,
//   serialises each character on a UART line and keeps the printer flag.
// - Returns skip and interrupt request to the bus as open-drain (0 or z) lines.
// PARAMETERS
// DEVICE        6'o04  device code compared against MB3-8
// CLKS_PER_BIT  9091   clocks per serial bit (1 MHz clk, 110 baud); min 2
// STOP_BITS     2      stop bits per frame, 1 or 2
// PORTS
// clk       in   1   system clock
// rst_n     in   1   asynchronous active-low reset
// bmb_n     in   12  buffered MB, active-low; bmb_n[11]=MB0 .. bmb_n[0]=MB11
// bac_n     in   8   buffered AC4-11, active-low; bac_n[7]=AC4
// iop1_n    in   1   IOP1 pulse, active-low
// iop2_n    in   1   IOP2 pulse, active-low
// iop4_n    in   1   IOP4 pulse, active-low
// init_n    in   1   bus initialize, active-low level
// skip_n    out  1   open-drain skip: 0 or z
// int_rq_n  out  1   open-drain interrupt request: 0 or z
// tx        out  1   serial data, idle high
// flag      out  1   printer flag, for console lamp
// busy      out  1   1 while a frame is shifting out
// BEHAVIOUR
// - Bus inputs are synchronous to clk. sel = (~bmb_n[8:3] == DEVICE).
// - Each iopN_n is registered once. Event N = registered value 1 while the
//   current value is 0 (falling edge), qualified by sel. Event lasts 1 cycle.
// - IOP1 (6041 TSF): if flag=1 at the event, skip_n drives 0 from the next cycle
//   until iop1_n returns high. Otherwise skip_n stays z.
// - IOP2 (6042 TCF): clears flag on the next edge.
// - IOP4 (6044 TPC, 6046 TLS): loads ~bac_n into hold and sets hold_v.
//   TLS is IOP2 followed by IOP4; no special case is needed.
// - int_rq_n = flag ? 0 : z. skip_n/int_rq_n never drive 1.
// - Transmitter FSM, states IDLE, START, DATA, STOP:
//   IDLE : tx=1. If hold_v, move shreg<=hold, clear hold_v, go START next cycle.
//   START: tx=0 for CLKS_PER_BIT clocks.
//   DATA : 8 bits, LSB first, CLKS_PER_BIT each.
//   STOP : tx=1 for STOP_BITS*CLKS_PER_BIT clocks. On the last clock, set flag and
//          go IDLE.
//   busy=1 in START/DATA/STOP. The bit counter is 3 bits and the divider counter
//   is $clog2(CLKS_PER_BIT) bits, both reloaded on each state entry.
// - Single holding register: IOP4 while busy is accepted into hold and sent after
//   the current frame. IOP4 while hold_v=1 overwrites hold; the older char is lost.
// - If the flag clear (IOP2) and frame completion fall in the same cycle, the set
//   wins and flag=1.
// - IOP4 in the same cycle as the IDLE->START transfer: hold reloads with the new
//   char and hold_v stays 1.
// - init_n=0 (synchronous): flag=0, hold_v=0, FSM->IDLE, tx=1. The frame in
//   flight is aborted and IOP events are ignored. Bus skip is released.
// - Reset (async): flag=0, hold_v=0, hold=0, shreg=0, state IDLE, tx=1, busy=0,
//   skip_n=z, int_rq_n=z, iop registers=1. Reset mid-frame truncates the frame
//   immediately.
// - Latency from the IOP4 event to tx falling is 2 clocks when idle (hold at +1,
//   START at +2).
// TESTING (CLKS_PER_BIT=4, STOP_BITS=2)
// - Reset mid-frame -> tx=1, busy=0, flag=0, skip_n/int_rq_n=z in the same cycle
//   reset is applied.
// - MB=6046, BAC AC4-11=0o301 -> tx low 2 clocks after the IOP4 edge. Bits
//   1,0,0,0,0,0,1,1 each 4 clocks, then 8 high clocks. flag=1 and int_rq_n=0 on
//   the last stop clock.
// - flag=1, MB=6041 IOP1 -> skip_n=0 one cycle after the edge, z when IOP1 rises.
//   Same with flag=0, or MB=6031 -> skip_n stays z.
// - Two TPCs 5 clocks apart (0x41, 0x42) then a third (0x43) before frame 1 ends
//   -> frames 0x41, 0x43 back-to-back with no idle gap beyond 1 clock; 0x42 lost.
// - IOP2 in the same cycle as the last stop clock -> flag=1 afterwards.
// - init_n=0 mid-DATA with hold_v=1 -> tx=1 next cycle, no further frame, flag=0.

Source files
------------

// File: rtl/kl8_printer_iot_if.sv
// Negative I/O bus slice seen by the KL8 teleprinter IOT.
// Skip and interrupt request are wired-OR open-drain lines with a bus pull-up.
interface kl8_printer_iot_if;
   logic [11:0] bmb_n;
   logic [7:0]  bac_n;
   logic        iop1_n;
   logic        iop2_n;
   logic        iop4_n;
   logic        init_n;
   tri1         skip_n;
   tri1         int_rq_n;

   modport master (
      output bmb_n, bac_n, iop1_n, iop2_n, iop4_n, init_n,
      input  skip_n, int_rq_n
   );

   modport slave (
      input  bmb_n, bac_n, iop1_n, iop2_n, iop4_n, init_n,
      output skip_n, int_rq_n
   );
endinterface

// File: rtl/kl8_printer_iot.sv
// KL8-style teleprinter output IOT: decodes TSF/TCF/TPC, keeps the printer flag,
// holds one pending character and shifts it out as an async serial frame.
module kl8_printer_iot #(
   parameter logic [5:0]  DEVICE       = 6'o04,
   parameter int unsigned CLKS_PER_BIT = 9091,
   parameter int unsigned STOP_BITS    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   kl8_printer_iot_if.slave bus,
   output logic             tx,
   output logic             flag,
   output logic             busy
);

   localparam int unsigned     DivW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [DivW-1:0] DivMax   = DivW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [7:0]      hold_q, hold_d;
   logic            hold_v_q, hold_v_d;
   logic            flag_q, flag_d;
   logic            skip_q, skip_d;
   logic            iop1_q, iop2_q, iop4_q;
   logic            sel, ev1, ev2, ev4;
   logic            load, frame_done;

   // Only MB3-8 take part in the device decode.
   logic unused_bmb;
   assign unused_bmb = ^{bus.bmb_n[11:9], bus.bmb_n[2:0]};

   // Device select and one-cycle IOP falling-edge events; init masks all events.
   always_comb begin
      sel = (~bus.bmb_n[8:3] == DEVICE);
      ev1 = sel & bus.init_n & iop1_q & ~bus.iop1_n;
      ev2 = sel & bus.init_n & iop2_q & ~bus.iop2_n;
      ev4 = sel & bus.init_n & iop4_q & ~bus.iop4_n;
   end

   // Previous IOP levels for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iop1_q <= 1'b1;
         iop2_q <= 1'b1;
         iop4_q <= 1'b1;
      end else begin
         iop1_q <= bus.iop1_n;
         iop2_q <= bus.iop2_n;
         iop4_q <= bus.iop4_n;
      end
   end

   // Transmitter next state: start bit, 8 data bits LSB first, STOP_BITS stop bits.
   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      load       = 1'b0;
      frame_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (hold_v_q) begin
               load    = 1'b1;
               shreg_d = hold_q;
               div_d   = DivMax;
               bit_d   = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (div_q == '0) begin
               div_d   = DivMax;
               bit_d   = '0;
               state_d = StData;
            end else begin
               div_d = div_q - 1'b1;
            end
         end
         StData: begin
            if (div_q == '0) begin
               div_d = DivMax;
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
                  state_d = StStop;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {1'b0, shreg_q[7:1]};
               end
            end else begin
               div_d = div_q - 1'b1;
            end
         end
         StStop: begin
            if (div_q == '0) begin
               if (bit_q == StopLast) begin
                  frame_done = 1'b1;
                  state_d    = StIdle;
               end else begin
                  bit_d = bit_q + 3'd1;
                  div_d = DivMax;
               end
            end else begin
               div_d = div_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      // Bus initialize aborts any frame in flight.
      if (!bus.init_n) begin
         state_d = StIdle;
      end
   end

   // Flag, holding register and skip next state.
   always_comb begin
      flag_d   = flag_q;
      hold_d   = hold_q;
      hold_v_d = hold_v_q;
      // Frame completion beats a simultaneous TCF.
      if (frame_done) begin
         flag_d = 1'b1;
      end else if (ev2) begin
         flag_d = 1'b0;
      end
      if (load) begin
         hold_v_d = 1'b0;
      end
      // A TPC landing on the transfer cycle re-arms the hold register.
      if (ev4) begin
         hold_d   = ~bus.bac_n;
         hold_v_d = 1'b1;
      end
      if (!bus.init_n) begin
         flag_d   = 1'b0;
         hold_v_d = 1'b0;
      end
      skip_d = bus.init_n & ~bus.iop1_n & (skip_q | (ev1 & flag_q));
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         div_q    <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         hold_q   <= '0;
         hold_v_q <= 1'b0;
         flag_q   <= 1'b0;
         skip_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         hold_q   <= hold_d;
         hold_v_q <= hold_v_d;
         flag_q   <= flag_d;
         skip_q   <= skip_d;
      end
   end

   // Serial line level and status outputs.
   always_comb begin
      tx = 1'b1;
      unique case (state_q)
         StIdle:  tx = 1'b1;
         StStart: tx = 1'b0;
         StData:  tx = shreg_q[0];
         StStop:  tx = 1'b1;
         default: tx = 1'b1;
      endcase
      busy = (state_q != StIdle);
      flag = flag_q;
   end

   // Open-drain bus returns: pull low or release, never drive high.
   assign bus.skip_n   = (skip_q & ~bus.iop1_n & bus.init_n) ? 1'b0 : 1'bz;
   assign bus.int_rq_n = flag_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_kl8_printer_iot.sv
// Bench for kl8_printer_iot: directed table and sequences, then random bus traffic
// compared each cycle against a frame-timing reference model.
`timescale 1ns/1ps
module tb_kl8_printer_iot;
   localparam int Cpb      = 4;
   localparam int Stop     = 2;
   localparam int FrameLen = (1 + 8 + Stop) * Cpb;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic tx, flag, busy;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;

   kl8_printer_iot_if bus ();

   kl8_printer_iot #(
      .DEVICE       (6'o04),
      .CLKS_PER_BIT (Cpb),
      .STOP_BITS    (Stop)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .tx    (tx),
      .flag  (flag),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_tpc(input logic [7:0] c);
      bus.bmb_n  = ~12'o6044;
      bus.bac_n  = ~c;
      bus.iop4_n = 1'b0;
      step();
      bus.iop4_n = 1'b1;
   endtask

   // Line level t clocks after the start bit begins.
   function automatic logic frame_bit(input logic [7:0] c, input int t);
      if (t < Cpb) return 1'b0;
      if (t < 9 * Cpb) return c[(t - Cpb) / Cpb];
      return 1'b1;
   endfunction

   function automatic logic b2b_exp(input int i);
      if (i >= 1 && i <= FrameLen) return frame_bit(8'h41, i - 1);
      if (i >= FrameLen + 2 && i <= 2 * FrameLen + 1) return frame_bit(8'h43, i - FrameLen - 2);
      return 1'b1;
   endfunction

   // Reference model: a frame is a character plus a clock count since its start bit.
   bit         m_flag, m_hold_v, m_active, m_skip;
   logic [7:0] m_hold, m_char;
   int         m_t;
   logic       m_p1, m_p2, m_p4;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_flag = 0; m_hold_v = 0; m_active = 0; m_skip = 0;
         m_hold = '0; m_char = '0; m_t = 0;
         m_p1 = 1'b1; m_p2 = 1'b1; m_p4 = 1'b1;
      end else begin : upd
         bit en, sel, e1, e2, e4, last;
         en   = bus.init_n;
         sel  = (~bus.bmb_n[8:3] == 6'o04);
         e1   = en && sel && m_p1 && !bus.iop1_n;
         e2   = en && sel && m_p2 && !bus.iop2_n;
         e4   = en && sel && m_p4 && !bus.iop4_n;
         last = m_active && (m_t == FrameLen - 1);
         m_skip = en && !bus.iop1_n && (m_skip || (e1 && m_flag));
         if (!en) begin
            m_flag = 0; m_hold_v = 0; m_active = 0;
         end else begin
            if (last) m_flag = 1;
            else if (e2) m_flag = 0;
            if (m_active) begin
               if (last) m_active = 0;
               else m_t++;
            end else if (m_hold_v) begin
               m_active = 1; m_t = 0; m_char = m_hold; m_hold_v = 0;
            end
            if (e4) begin
               m_hold = ~bus.bac_n; m_hold_v = 1;
            end
         end
         m_p1 = bus.iop1_n; m_p2 = bus.iop2_n; m_p4 = bus.iop4_n;
      end
   end

   always @(posedge clk) begin
      #3;
      if (chk_en) begin
         logic [4:0] got, exp;
         got = {tx, busy, flag, bus.skip_n === 1'b0, bus.int_rq_n === 1'b0};
         exp = {m_active ? frame_bit(m_char, m_t) : 1'b1, m_active, m_flag,
                m_skip && !bus.iop1_n && bus.init_n, m_flag};
         check("model{tx,busy,flag,skip,int}", 32'(got), 32'(exp));
      end
   end

   typedef struct {
      logic [11:0] mb;
      logic        iop1;
      logic        iop2;
      logic        exp_skip;
      logic        exp_int;
   } vec_t;

   vec_t vt[14];

   initial begin
      vt[0]  = '{12'o6041, 1'b1, 1'b1, 1'b0, 1'b1};
      vt[1]  = '{12'o6041, 1'b0, 1'b1, 1'b0, 1'b1};
      vt[2]  = '{12'o6041, 1'b0, 1'b1, 1'b1, 1'b1};
      vt[3]  = '{12'o6041, 1'b0, 1'b1, 1'b1, 1'b1};
      vt[4]  = '{12'o6041, 1'b1, 1'b1, 1'b0, 1'b1};
      vt[5]  = '{12'o6031, 1'b1, 1'b1, 1'b0, 1'b1};
      vt[6]  = '{12'o6031, 1'b0, 1'b1, 1'b0, 1'b1};
      vt[7]  = '{12'o6031, 1'b0, 1'b1, 1'b0, 1'b1};
      vt[8]  = '{12'o6031, 1'b1, 1'b1, 1'b0, 1'b1};
      vt[9]  = '{12'o6042, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[10] = '{12'o6042, 1'b1, 1'b1, 1'b0, 1'b0};
      vt[11] = '{12'o6041, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[12] = '{12'o6041, 1'b0, 1'b1, 1'b0, 1'b0};
      vt[13] = '{12'o6041, 1'b1, 1'b1, 1'b0, 1'b0};

      bus.bmb_n = '1; bus.bac_n = '1; bus.init_n = 1'b1;
      bus.iop1_n = 1'b1; bus.iop2_n = 1'b1; bus.iop4_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      #2;
      check("rst_tx", tx, 1); check("rst_busy", busy, 0); check("rst_flag", flag, 0);
      check("rst_skip", bus.skip_n === 1'b0, 0); check("rst_int", bus.int_rq_n === 1'b0, 0);

      // TLS 6046 with AC4-11 = 0o301.
      bus.bmb_n = ~12'o6046; bus.bac_n = ~8'o301; bus.iop2_n = 1'b0;
      step(); bus.iop2_n = 1'b1; bus.iop4_n = 1'b0;
      step(); bus.iop4_n = 1'b1;
      #2 check("tls_pre_tx", tx, 1); check("tls_pre_busy", busy, 0);
      for (int k = 0; k < FrameLen; k++) begin
         step(); #2;
         check("tls_tx", tx, frame_bit(8'o301, k));
         check("tls_busy", busy, 1);
      end
      check("tls_flag_in_stop", flag, 0);
      step(); #2;
      check("tls_flag", flag, 1); check("tls_int", bus.int_rq_n === 1'b0, 1);
      check("tls_done_busy", busy, 0);

      // TSF/TCF vectors; flag is 1 at entry.
      for (int i = 0; i < 14; i++) begin
         step();
         bus.bmb_n = ~vt[i].mb; bus.iop1_n = vt[i].iop1; bus.iop2_n = vt[i].iop2;
         #2;
         check($sformatf("vec%0d_skip", i), bus.skip_n === 1'b0, vt[i].exp_skip);
         check($sformatf("vec%0d_int", i), bus.int_rq_n === 1'b0, vt[i].exp_int);
      end

      // Back-to-back TPCs: 0x42 is overwritten by 0x43 before frame 1 ends.
      step(); send_tpc(8'h41);
      for (int i = 0; i < 100; i++) begin
         #2;
         check($sformatf("b2b_tx%0d", i), tx, b2b_exp(i));
         if (i == FrameLen + 1) check("b2b_gap_busy", busy, 0);
         if (i == 4) send_tpc(8'h42);
         else if (i == 15) send_tpc(8'h43);
         else step();
      end

      // TCF on the last stop clock: set wins.
      bus.bmb_n = ~12'o6042; bus.iop2_n = 1'b0;
      step(); bus.iop2_n = 1'b1;
      #2 check("tcf_clear", flag, 0);
      send_tpc(8'h5a);
      for (int i = 0; i <= FrameLen; i++) begin
         #2;
         if (i == FrameLen) begin
            check("coll_busy", busy, 1); check("coll_flag_pre", flag, 0);
            bus.bmb_n = ~12'o6042; bus.iop2_n = 1'b0;
            step(); bus.iop2_n = 1'b1;
         end else begin
            step();
         end
      end
      #2 check("coll_flag", flag, 1);

      // Async reset mid-frame while skip and interrupt are asserted.
      send_tpc(8'h3c);
      for (int i = 0; i < 20; i++) begin
         #2;
         if (i == 10) begin bus.bmb_n = ~12'o6041; bus.iop1_n = 1'b0; end
         if (i == 13) check("pre_rst_skip", bus.skip_n === 1'b0, 1);
         step();
      end
      #2 check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mrst_tx", tx, 1); check("mrst_busy", busy, 0); check("mrst_flag", flag, 0);
      check("mrst_skip", bus.skip_n === 1'b0, 0); check("mrst_int", bus.int_rq_n === 1'b0, 0);
      bus.iop1_n = 1'b1;
      step(); step();
      rst_n = 1'b1;

      // Bus initialize mid-DATA with a character waiting in hold.
      send_tpc(8'h55);
      for (int i = 0; i < 20; i++) begin
         #2;
         if (i == 8) send_tpc(8'h66);
         else step();
      end
      #2 check("pre_init_busy", busy, 1);
      bus.init_n = 1'b0;
      step(); #2;
      check("init_tx", tx, 1); check("init_busy", busy, 0); check("init_flag", flag, 0);
      step(); bus.init_n = 1'b1;
      for (int i = 0; i < 60; i++) begin
         step(); #2;
         check("init_no_frame", {tx, busy}, 2'b10);
      end

      // Random bus traffic against the reference model.
      step();
      chk_en = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         step();
         bus.init_n = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 9) < 8) bus.bmb_n = ~{3'o6, 6'o04, 3'($urandom_range(0, 7))};
         else bus.bmb_n = 12'($urandom);
         bus.bac_n  = 8'($urandom);
         bus.iop1_n = bus.iop1_n ? ($urandom_range(0, 24) != 0) : ($urandom_range(0, 1) == 0);
         bus.iop2_n = bus.iop2_n ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 1) == 0);
         bus.iop4_n = bus.iop4_n ? ($urandom_range(0, 59) != 0) : ($urandom_range(0, 1) == 0);
      end
      step(); #4;
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
